// File: rtl/meter_counter.sv
// Parking-meter time register: coin adds, presets, 1 Hz countdown with saturation,
// plus a registered meter state and a blank strobe for flashing the display.
module meter_counter #(
  parameter int SEC_MAX    = 3599,
  parameter int LOW_THRESH = 180,
  parameter int ADD_A      = 60,
  parameter int ADD_B      = 120,
  parameter int ADD_C      = 180,
  parameter int ADD_D      = 300,
  parameter int PRESET_A   = 10,
  parameter int PRESET_B   = 205
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic [3:0]  btn_add,
  input  logic [1:0]  btn_preset,
  output logic [11:0] sec_count,
  output logic [1:0]  state,
  output logic        blank
);

  localparam logic [1:0] ST_EXPIRED = 2'b00;
  localparam logic [1:0] ST_LOW     = 2'b01;
  localparam logic [1:0] ST_NORMAL  = 2'b10;

  logic [5:0]  btn_prev_r;
  logic [3:0]  press_add_s;
  logic [1:0]  press_pre_s;
  logic [13:0] add_sum_s;
  logic        dec_s;
  logic [13:0] sum_s;
  logic [11:0] next_count_s;
  logic [1:0]  next_state_s;
  logic        next_blank_s;

  // Next count, next state and next blank from presses, tick and current count
  always_comb begin
    press_add_s = btn_add & ~btn_prev_r[3:0];
    press_pre_s = btn_preset & ~btn_prev_r[5:4];

    add_sum_s = 14'd0;
    if (press_add_s[0]) add_sum_s = add_sum_s + 14'(ADD_A); else add_sum_s = add_sum_s;
    if (press_add_s[1]) add_sum_s = add_sum_s + 14'(ADD_B); else add_sum_s = add_sum_s;
    if (press_add_s[2]) add_sum_s = add_sum_s + 14'(ADD_C); else add_sum_s = add_sum_s;
    if (press_add_s[3]) add_sum_s = add_sum_s + 14'(ADD_D); else add_sum_s = add_sum_s;

    // dec is only set for a nonzero count, so the subtraction cannot underflow
    dec_s = tick_1hz & (sec_count != 12'd0);
    sum_s = {2'b00, sec_count} + add_sum_s - {13'd0, dec_s};

    if (press_pre_s[0]) begin
      next_count_s = 12'(PRESET_A);
    end else if (press_pre_s[1]) begin
      next_count_s = 12'(PRESET_B);
    end else if (sum_s > 14'(SEC_MAX)) begin
      next_count_s = 12'(SEC_MAX);
    end else begin
      next_count_s = sum_s[11:0];
    end

    if (next_count_s == 12'd0) begin
      next_state_s = ST_EXPIRED;
    end else if (next_count_s < 12'(LOW_THRESH)) begin
      next_state_s = ST_LOW;
    end else begin
      next_state_s = ST_NORMAL;
    end

    // Any new time or state change shows the display immediately
    if (next_state_s == ST_NORMAL) begin
      next_blank_s = 1'b0;
    end else if (next_state_s != state) begin
      next_blank_s = 1'b0;
    end else if ((|press_pre_s) || (|press_add_s)) begin
      next_blank_s = 1'b0;
    end else if (tick_1hz) begin
      next_blank_s = ~blank;
    end else begin
      next_blank_s = blank;
    end
  end

  // Output and button-history registers; buttons held through reset stay armed off
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_r <= 6'b111111;
      sec_count  <= 12'd0;
      state      <= ST_EXPIRED;
      blank      <= 1'b0;
    end else begin
      btn_prev_r <= {btn_preset, btn_add};
      sec_count  <= next_count_s;
      state      <= next_state_s;
      blank      <= next_blank_s;
    end
  end

endmodule

// File: tb/tb_meter_counter.sv
// Scoreboard bench for meter_counter: directed steps push expected outputs,
// a monitor pops and compares them after the clock edge they belong to.
module tb_meter_counter;

  logic        clk;
  logic        rst;
  logic        tick_1hz;
  logic [3:0]  btn_add;
  logic [1:0]  btn_preset;
  logic [11:0] sec_count;
  logic [1:0]  state;
  logic        blank;

  localparam logic [1:0] EXP = 2'b00;
  localparam logic [1:0] LOW = 2'b01;
  localparam logic [1:0] NRM = 2'b10;

  typedef struct {
    int          tag;
    logic [11:0] sec;
    logic [1:0]  st;
    logic        b;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   total;
  int   bad;

  meter_counter dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .btn_add    (btn_add),
    .btn_preset (btn_preset),
    .sec_count  (sec_count),
    .state      (state),
    .blank      (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: after each edge, compare every expectation due by now
  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        total = total + 1;
        if (e.tag != cyc || sec_count !== e.sec || state !== e.st || blank !== e.b) begin
          bad = bad + 1;
          $display("FAIL step@%0d (now %0d): got sec=%0d state=%0d blank=%0d, want sec=%0d state=%0d blank=%0d",
                   e.tag, cyc, sec_count, state, blank, e.sec, e.st, e.b);
        end
      end
    end
  end

  // One clock of stimulus; expectation is for the outputs after the coming edge
  task automatic step(input logic r, input logic t, input logic [3:0] a, input logic [1:0] p,
                      input logic [11:0] es, input logic [1:0] est, input logic eb);
    exp_t e;
    @(negedge clk);
    rst = r; tick_1hz = t; btn_add = a; btn_preset = p;
    e.tag = cyc + 1; e.sec = es; e.st = est; e.b = eb;
    exp_q.push_back(e);
  endtask

  initial begin
    cyc = 0; total = 0; bad = 0;
    rst = 1'b1; tick_1hz = 1'b0; btn_add = 4'd0; btn_preset = 2'd0;

    // 1: reset, idle, tick at zero
    step(1'b1, 1'b0, 4'd0, 2'd0, 12'd0, EXP, 1'b0);
    step(1'b1, 1'b0, 4'd0, 2'd0, 12'd0, EXP, 1'b0);
    step(1'b0, 1'b0, 4'd0, 2'd0, 12'd0, EXP, 1'b0);
    step(1'b0, 1'b1, 4'd0, 2'd0, 12'd0, EXP, 1'b1);
    step(1'b0, 1'b1, 4'd0, 2'd0, 12'd0, EXP, 1'b0);

    // 2: hold btn_add[3] for 10 cycles -> single add of 300
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'b1000, 2'd0, 12'd300, NRM, 1'b0);
    step(1'b0, 1'b0, 4'd0, 2'd0, 12'd300, NRM, 1'b0);

    // 3: preset 205, count down to 181, then cross the LOW threshold
    step(1'b0, 1'b0, 4'd0, 2'b10, 12'd205, NRM, 1'b0);
    for (int k = 1; k <= 24; k++) step(1'b0, 1'b1, 4'd0, 2'b00, 12'(205 - k), NRM, 1'b0);
    step(1'b0, 1'b1, 4'd0, 2'd0, 12'd180, NRM, 1'b0);
    step(1'b0, 1'b1, 4'd0, 2'd0, 12'd179, LOW, 1'b0);
    step(1'b0, 1'b1, 4'd0, 2'd0, 12'd178, LOW, 1'b1);
    step(1'b0, 1'b1, 4'd0, 2'd0, 12'd177, LOW, 1'b0);
    step(1'b0, 1'b0, 4'd0, 2'd0, 12'd177, LOW, 1'b0);

    // 4: build up to 3500, then saturate
    step(1'b0, 1'b0, 4'd0, 2'b10, 12'd205, NRM, 1'b0);
    step(1'b0, 1'b0, 4'd0, 2'b00, 12'd205, NRM, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      step(1'b0, 1'b0, 4'b1000, 2'd0, 12'(205 + 300 * k), NRM, 1'b0);
      step(1'b0, 1'b0, 4'b0000, 2'd0, 12'(205 + 300 * k), NRM, 1'b0);
    end
    for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 4'd0, 2'd0, 12'(3505 - k), NRM, 1'b0);
    step(1'b0, 1'b0, 4'b1000, 2'd0, 12'd3599, NRM, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 2'd0, 12'd3599, NRM, 1'b0);
    step(1'b0, 1'b0, 4'b0001, 2'd0, 12'd3599, NRM, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 2'd0, 12'd3599, NRM, 1'b0);

    // 5: tick and add together at 1; two adds together from 0
    step(1'b0, 1'b0, 4'd0, 2'b01, 12'd10, LOW, 1'b0);
    step(1'b0, 1'b0, 4'd0, 2'b00, 12'd10, LOW, 1'b0);
    for (int k = 1; k <= 9; k++) step(1'b0, 1'b1, 4'd0, 2'd0, 12'(10 - k), LOW, 1'(k % 2));
    step(1'b0, 1'b1, 4'b0001, 2'd0, 12'd60, LOW, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 2'd0, 12'd60, LOW, 1'b0);
    step(1'b0, 1'b0, 4'd0, 2'b01, 12'd10, LOW, 1'b0);
    step(1'b0, 1'b0, 4'd0, 2'b00, 12'd10, LOW, 1'b0);
    for (int k = 1; k <= 9; k++) step(1'b0, 1'b1, 4'd0, 2'd0, 12'(10 - k), LOW, 1'(k % 2));
    step(1'b0, 1'b1, 4'd0, 2'd0, 12'd0, EXP, 1'b0);
    step(1'b0, 1'b0, 4'b0011, 2'd0, 12'd180, NRM, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 2'd0, 12'd180, NRM, 1'b0);

    // 6: preset beats add, preset A beats B, button held through reset
    step(1'b0, 1'b0, 4'b1000, 2'b10, 12'd205, NRM, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 2'b00, 12'd205, NRM, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 2'b11, 12'd10, LOW, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 2'b00, 12'd10, LOW, 1'b0);
    step(1'b1, 1'b1, 4'b0100, 2'b00, 12'd0, EXP, 1'b0);
    step(1'b0, 1'b0, 4'b0100, 2'b00, 12'd0, EXP, 1'b0);
    step(1'b0, 1'b0, 4'b0100, 2'b00, 12'd0, EXP, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 2'b00, 12'd0, EXP, 1'b0);
    step(1'b0, 1'b0, 4'b0100, 2'b00, 12'd180, NRM, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 2'b00, 12'd180, NRM, 1'b0);

    // Drain: every expectation must have been consumed within a few cycles
    repeat (4) @(posedge clk);
    #3;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
